// File: rtl/neural_input_loader_pkg.sv
// Loader FSM state encodings shared with control_unit, plus a channel-index width helper.
package neural_input_loader_pkg;

  localparam logic [2:0] LDR_IDLE    = 3'd0;
  localparam logic [2:0] LDR_FETCH   = 3'd1;
  localparam logic [2:0] LDR_LAND    = 3'd2;
  localparam logic [2:0] LDR_PRESENT = 3'd3;
  localparam logic [2:0] LDR_DONE    = 3'd4;

  function automatic int chan_w(input int sx);
    return (sx > 1) ? $clog2(sx) : 1;
  endfunction

endpackage

// File: rtl/neural_input_loader_bank.sv
// SX-word sample register bank; full rises with the last channel write, clears on transfer.
module input_bank #(
  parameter int N  = 16,
  parameter int SX = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [SX-1:0]   we_i,
  input  logic [N-1:0]    wdata_i,
  input  logic            clr_i,
  output logic [N*SX-1:0] data_o,
  output logic            full_o
);

  logic [SX-1:0][N-1:0] data_q;
  logic                 full_q;

  for (genvar k = 0; k < SX; k++) begin : g_ch
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       data_q[k] <= '0;
      else if (we_i[k])  data_q[k] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            full_q <= 1'b0;
    else if (we_i[SX-1])    full_q <= 1'b1;
    else if (clr_i)         full_q <= 1'b0;
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/neural_input_loader.sv
// Batch sample loader: reads SX words per sample from x RAM, presents them on nx with valid/ready.
// Define NEURAL_LOADER_DOUBLE_BUF_EN for ping-pong banks (fetch overlaps presentation).
module neural_input_loader
  import neural_input_loader_pkg::*;
#(
  parameter int A  = 32,
  parameter int N  = 16,
  parameter int SX = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [N-1:0]    batch_i,
  input  logic [A-1:0]    base_i,
  input  logic [N-1:0]    bus_i,
  output logic [A-1:0]    x_addr_o,
  output logic            e_x_o,
  output logic [N*SX-1:0] nx_o,
  output logic            nx_valid_o,
  input  logic            nx_ready_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [N-1:0]    sample_idx_o
);

`ifdef NEURAL_LOADER_DOUBLE_BUF_EN
  localparam int   NB  = 2;
  localparam logic DBL = 1'b1;
`else
  localparam int   NB  = 1;
  localparam logic DBL = 1'b0;
`endif
  localparam int CW = chan_w(SX);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] ch_q, ch_d, cap_ch_q, cap_ch_d;
  logic [A-1:0]  addr_q, addr_d;
  logic [N-1:0]  batch_q, batch_d, fcnt_q, fcnt_d, sidx_q, sidx_d;
  logic          fb_q, fb_d, pres_q, pres_d, cap_bank_q, cap_bank_d, cap_vld_q, cap_vld_d;

  logic [NB-1:0][N*SX-1:0] bank_data;
  logic [NB-1:0][SX-1:0]   bank_we;
  logic [NB-1:0]           bank_full, bank_clr, bank_free;
  logic                    xfer, last, more;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    assign bank_clr[b]  = xfer && (pres_q == 1'(b));
    // A bank being handed off this cycle may be refilled starting next cycle.
    assign bank_free[b] = !bank_full[b] || bank_clr[b];
    input_bank #(.N(N), .SX(SX)) u_bank (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (bank_we[b]),
      .wdata_i (bus_i),
      .clr_i   (bank_clr[b]),
      .data_o  (bank_data[b]),
      .full_o  (bank_full[b])
    );
  end

  always_comb begin
    bank_we = '0;
    if (cap_vld_q) bank_we[cap_bank_q][cap_ch_q] = 1'b1;
  end

  assign nx_valid_o   = bank_full[pres_q];
  assign nx_o         = bank_data[pres_q];
  assign xfer         = nx_valid_o && nx_ready_i;
  assign last         = (sidx_q == batch_q - N'(1));
  assign more         = (fcnt_q != batch_q);
  assign x_addr_o     = addr_q;
  // Bus stays enabled through the capture cycle that trails the last address.
  assign e_x_o        = (state_q == LDR_FETCH) || cap_vld_q;
  assign busy_o       = (state_q == LDR_FETCH) || (state_q == LDR_LAND) || (state_q == LDR_PRESENT);
  assign done_o       = (state_q == LDR_DONE);
  assign sample_idx_o = sidx_q;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    addr_d     = addr_q;
    batch_d    = batch_q;
    fcnt_d     = fcnt_q;
    sidx_d     = sidx_q;
    fb_d       = fb_q;
    pres_d     = pres_q;
    cap_vld_d  = 1'b0;
    cap_ch_d   = cap_ch_q;
    cap_bank_d = cap_bank_q;
    if (xfer) begin
      pres_d = pres_q ^ DBL;
      sidx_d = sidx_q + N'(1);
    end
    case (state_q)
      LDR_IDLE: if (start_i) begin
        batch_d = batch_i;
        addr_d  = base_i;
        fcnt_d  = '0;
        sidx_d  = '0;
        ch_d    = '0;
        fb_d    = 1'b0;
        pres_d  = 1'b0;
        state_d = (batch_i == '0) ? LDR_DONE : LDR_FETCH;
      end
      LDR_FETCH: begin
        cap_vld_d  = 1'b1;
        cap_ch_d   = ch_q;
        cap_bank_d = fb_q;
        addr_d     = addr_q + A'(1);
        if (ch_q == CW'(SX - 1)) begin
          ch_d    = '0;
          fcnt_d  = fcnt_q + N'(1);
          state_d = LDR_LAND;
        end else begin
          ch_d = ch_q + CW'(1);
        end
      end
      LDR_LAND: begin
        fb_d = fb_q ^ DBL;
        if (DBL && more && bank_free[fb_q ^ 1'b1]) state_d = LDR_FETCH;
        else                                        state_d = LDR_PRESENT;
      end
      LDR_PRESENT: if (more && bank_free[fb_q]) state_d = LDR_FETCH;
      LDR_DONE:    state_d = LDR_IDLE;
      default:     state_d = LDR_IDLE;
    endcase
    if (xfer && last) begin
      state_d = LDR_DONE;
      sidx_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LDR_IDLE;
      ch_q       <= '0;
      addr_q     <= '0;
      batch_q    <= '0;
      fcnt_q     <= '0;
      sidx_q     <= '0;
      fb_q       <= 1'b0;
      pres_q     <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_ch_q   <= '0;
      cap_bank_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      addr_q     <= addr_d;
      batch_q    <= batch_d;
      fcnt_q     <= fcnt_d;
      sidx_q     <= sidx_d;
      fb_q       <= fb_d;
      pres_q     <= pres_d;
      cap_vld_q  <= cap_vld_d;
      cap_ch_q   <= cap_ch_d;
      cap_bank_q <= cap_bank_d;
    end
  end

endmodule

// File: tb/tb_neural_input_loader.sv
// Directed bench for neural_input_loader (SX=2, N=16, RAM[k]=0x0100*(k+1)) with a sample-level scoreboard.
module tb_neural_input_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] batch = '0;
  logic [31:0] base = '0;
  logic [15:0] bus = '0;
  logic [31:0] x_addr;
  logic        e_x;
  logic [31:0] nx;
  logic        nx_valid;
  logic        nx_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [15:0] sample_idx;

  neural_input_loader #(.A(32), .N(16), .SX(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .batch_i(batch), .base_i(base),
    .bus_i(bus), .x_addr_o(x_addr), .e_x_o(e_x), .nx_o(nx), .nx_valid_o(nx_valid),
    .nx_ready_i(nx_ready), .busy_o(busy), .done_o(done), .sample_idx_o(sample_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  // Model state: expected batch/base, transfers and done pulses seen.
  int          m_batch = 0;
  logic [31:0] m_base = '0;
  int          m_xfers = 0;
  int          m_dones = 0;
  logic        m_active = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_nx = '0;

  function automatic logic [15:0] ram(input logic [31:0] a);
    logic [31:0] t;
    t = a + 32'd1;
    return {t[7:0], 8'h00};
  endfunction

  function automatic logic [31:0] exp_nx(input int s);
    logic [31:0] a;
    a = m_base + 32'(s * 2);
    return {ram(a + 32'd1), ram(a)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // x RAM: one-cycle read latency, bus floats (stand-in value) when not enabled.
  always @(posedge clk) bus <= e_x ? ram(x_addr) : 16'hDEAD;
  always @(posedge clk) cyc++;

  function automatic int rel();
    return cyc - t0 + 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && m_active) begin
      if (prev_stall) begin
        chk("stall_valid_held", 64'(nx_valid), 64'(1));
        chk("stall_nx_stable", 64'(nx), 64'(prev_nx));
      end
      if (nx_valid && nx_ready) begin
        chk("nx_data", 64'(nx), 64'(exp_nx(m_xfers)));
        chk("sample_idx", 64'(sample_idx), 64'(m_xfers));
        m_xfers++;
      end
      if (done) begin
        m_dones++;
        chk("done_after_all_xfers", 64'(m_xfers), 64'(m_batch));
        chk("busy_low_at_done", 64'(busy), 64'(0));
      end
      prev_stall = nx_valid && !nx_ready;
      prev_nx    = nx;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic go(input logic [15:0] b, input logic [31:0] bs);
    m_batch = int'(b); m_base = bs; m_xfers = 0; m_dones = 0; prev_stall = 1'b0; m_active = 1'b1;
    start = 1'b1; batch = b; base = bs;
    @(posedge clk); #2;
    start = 1'b0; t0 = cyc;
  endtask

  task automatic wait_done(input int bound, output int dc);
    bit seen;
    seen = 0; dc = -1;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; dc = rel(); end
    end
    chk("done_within_bound", 64'(seen), 64'(1));
  endtask

`ifdef NEURAL_LOADER_DOUBLE_BUF_EN
  localparam int DONE3 = 11, DONE_STALL = 11, STALL_EX = 3;
`else
  localparam int DONE3 = 13, DONE_STALL = 14, STALL_EX = 0;
`endif

  initial begin
    int dc, ecnt, any;

    // reset state
    @(negedge clk);
    chk("rst_x_addr", 64'(x_addr), 64'(0));
    chk("rst_e_x", 64'(e_x), 64'(0));
    chk("rst_nx_valid", 64'(nx_valid), 64'(0));
    chk("rst_busy_done", 64'({busy, done}), 64'(0));
    chk("rst_nx", 64'(nx), 64'(0));
    step(); rst_n = 1'b1; step();

    // batch=3 base=0, ready=1
    go(16'd3, 32'd0);
    @(negedge clk);
    chk("a_c1_addr", 64'(x_addr), 64'(0));
    chk("a_c1_ex_busy", 64'({e_x, busy, nx_valid}), 64'(3'b110));
    @(negedge clk);
    chk("a_c2_addr", 64'(x_addr), 64'(1));
    @(negedge clk);
    chk("a_c3_land", 64'({e_x, nx_valid}), 64'(2'b10));
    @(negedge clk);
    chk("a_c4_valid", 64'(nx_valid), 64'(1));
    chk("a_c4_nx", 64'(nx), 64'(32'h0200_0100));
    wait_done(40, dc);
    chk("a_done_cycle", 64'(dc), 64'(DONE3));
    chk("a_idx_zero", 64'(sample_idx), 64'(0));
    repeat (4) @(negedge clk);
    chk("a_single_done", 64'(m_dones), 64'(1));
    chk("a_xfers", 64'(m_xfers), 64'(3));
    step();

    // batch=2, sample 0 held 5 cycles
    nx_ready = 1'b0;
    go(16'd2, 32'd0);
    repeat (4) @(negedge clk);
    ecnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      ecnt += int'(e_x);
`ifdef NEURAL_LOADER_DOUBLE_BUF_EN
      if (i < 2) chk("b_prefetch_addr", 64'(x_addr), 64'(2 + i));
`endif
    end
    chk("b_stall_ex_cycles", 64'(ecnt), 64'(STALL_EX));
    chk("b_stall_nx", 64'(nx), 64'(32'h0200_0100));
    step(); nx_ready = 1'b1;
    wait_done(40, dc);
    chk("b_done_cycle", 64'(dc), 64'(DONE_STALL));
    step();

    // batch=0
    go(16'd0, 32'd0);
    @(negedge clk);
    chk("c_done_c1", 64'({done, busy, e_x, nx_valid}), 64'(4'b1000));
    any = 0;
    repeat (4) begin
      @(negedge clk);
      any += int'(done | busy | e_x | nx_valid);
    end
    chk("c_quiet_after", 64'(any), 64'(0));
    chk("c_single_done", 64'(m_dones), 64'(1));
    step();

    // address wrap
    go(16'd1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("d_addr_top", 64'(x_addr), 64'(32'hFFFF_FFFF));
    @(negedge clk);
    chk("d_addr_wrap", 64'(x_addr), 64'(0));
    repeat (2) @(negedge clk);
    chk("d_nx", 64'(nx), 64'(32'h0100_0000));
    wait_done(20, dc);
    step();

    // reset during second FETCH cycle
    go(16'd3, 32'd0);
    step();
    m_active = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("e_rst_out", 64'({x_addr, e_x, nx_valid, busy, done}), 64'(0));
    chk("e_rst_idx_nx", 64'({sample_idx, nx}), 64'(0));
    step(); rst_n = 1'b1; step();
    go(16'd3, 32'd4);
    wait_done(40, dc);
    chk("e_done_cycle", 64'(dc), 64'(DONE3));
    chk("e_xfers", 64'(m_xfers), 64'(3));
    step();

    // start ignored while busy
    go(16'd3, 32'd0);
    repeat (5) @(negedge clk);
    step();
    start = 1'b1; batch = 16'd7; base = 32'h40;
    step();
    start = 1'b0;
    wait_done(40, dc);
    chk("f_done_cycle", 64'(dc), 64'(DONE3));
    repeat (4) @(negedge clk);
    chk("f_single_done", 64'(m_dones), 64'(1));
    chk("f_no_restart", 64'({busy, e_x}), 64'(0));
    chk("f_xfers", 64'(m_xfers), 64'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
